// File: rtl/alu_instr_control_unit.sv
// Moore control unit that sequences fetch (T0-T2) and execute (T3-T6) for register-register ALU ops.
// Optional retired-instruction counter enabled by defining CU_RETIRE_COUNT_EN.
module alu_instr_control_unit #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_rdy,
  output logic            pc_out,
  output logic            mar_in,
  output logic            inc_pc,
  output logic            pc_in,
  output logic            read,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            y_in,
  output logic            zlow_in,
  output logic            zhigh_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            hi_in,
  output logic            lo_in,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic [OPW-1:0]  alu_op,
  output logic            halted,
  output logic            illegal
`ifdef CU_RETIRE_COUNT_EN
  ,
  output logic [31:0]     retired
`endif
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  typedef struct packed {
    logic            pc_out;
    logic            mar_in;
    logic            inc_pc;
    logic            pc_in;
    logic            read;
    logic            mdr_in;
    logic            mdr_out;
    logic            ir_in;
    logic            y_in;
    logic            zlow_in;
    logic            zhigh_in;
    logic            zlow_out;
    logic            zhigh_out;
    logic            hi_in;
    logic            lo_in;
    logic            halted;
    logic            illegal;
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic [OPW-1:0]  alu_op;
  } ctl_t;

  state_t         state, nxt;
  logic [OPW-1:0] op_q, op_n;
  logic [3:0]     ra_q, rb_q, rc_q, ra_n, rb_n, rc_n;
  ctl_t           ctl_q;
  logic           unused_ir;

  assign unused_ir = ^ir[14:0];

  function automatic logic is_alu(input logic [OPW-1:0] o);
    case (o)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [OPW-1:0] o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

  // Control word for a given state; registered so outputs never see ir directly.
  function automatic ctl_t ctl_for(input state_t s, input logic [OPW-1:0] o,
                                   input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] c);
    ctl_t w;
    w = '0;
    case (s)
      T0: begin
        w.pc_out = 1'b1; w.mar_in = 1'b1; w.inc_pc = 1'b1;
        w.zlow_in = 1'b1; w.zhigh_in = 1'b1;
      end
      T1: begin
        w.zlow_out = 1'b1; w.pc_in = 1'b1; w.read = 1'b1; w.mdr_in = 1'b1;
      end
      T2: begin
        w.mdr_out = 1'b1; w.ir_in = 1'b1;
      end
      T3: begin
        if (is_alu(o)) begin
          w.rout = NREG'(1) << b;
          w.y_in = 1'b1;
        end else if (o != OP_NOP && o != OP_HALT) begin
          w.illegal = 1'b1;
        end
      end
      T4: begin
        w.rout = NREG'(1) << c;
        w.alu_op = o;
        w.zlow_in = 1'b1; w.zhigh_in = 1'b1;
      end
      T5: begin
        w.zlow_out = 1'b1;
        if (is_muldiv(o)) w.lo_in = 1'b1;
        else              w.rin = NREG'(1) << a;
      end
      T6: begin
        w.zhigh_out = 1'b1; w.hi_in = 1'b1;
      end
      HALT: w.halted = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (run) nxt = T0;
      T0:   nxt = T1;
      T1:   if (mem_rdy) nxt = T2;
      T2:   nxt = T3;
      T3: begin
        if (is_alu(op_q))        nxt = T4;
        else if (op_q == OP_HALT) nxt = HALT;
        else                     nxt = run ? T0 : IDLE;
      end
      T4:   nxt = T5;
      T5:   nxt = is_muldiv(op_q) ? T6 : (run ? T0 : IDLE);
      T6:   nxt = run ? T0 : IDLE;
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // Decode fields are captured on the T2->T3 edge and held for the whole execute phase.
  assign op_n = (state == T2) ? ir[31 -: OPW] : op_q;
  assign ra_n = (state == T2) ? ir[26:23]     : ra_q;
  assign rb_n = (state == T2) ? ir[22:19]     : rb_q;
  assign rc_n = (state == T2) ? ir[18:15]     : rc_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      ctl_q <= '0;
    end else begin
      state <= nxt;
      op_q  <= op_n;
      ra_q  <= ra_n;
      rb_q  <= rb_n;
      rc_q  <= rc_n;
      ctl_q <= ctl_for(nxt, op_n, ra_n, rb_n, rc_n);
    end
  end

  assign {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
          zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in, halted, illegal,
          rin, rout, alu_op} = ctl_q;

`ifdef CU_RETIRE_COUNT_EN
  // An instruction retires on leaving its final write-back state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      retired <= '0;
    else if ((state == T5 && !is_muldiv(op_q)) || state == T6)
      retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_instr_control_unit.sv
// Scoreboard bench for alu_instr_control_unit: cycle-tagged expected control words
// are queued by the stimulus and compared by an independent monitor.
module tb_alu_instr_control_unit;
  localparam int NREG = 16;
  localparam int OPW  = 5;
  typedef logic [53:0] vec_t;

  localparam vec_t V_PC_OUT    = vec_t'(1) << 53;
  localparam vec_t V_MAR_IN    = vec_t'(1) << 52;
  localparam vec_t V_INC_PC    = vec_t'(1) << 51;
  localparam vec_t V_PC_IN     = vec_t'(1) << 50;
  localparam vec_t V_READ      = vec_t'(1) << 49;
  localparam vec_t V_MDR_IN    = vec_t'(1) << 48;
  localparam vec_t V_MDR_OUT   = vec_t'(1) << 47;
  localparam vec_t V_IR_IN     = vec_t'(1) << 46;
  localparam vec_t V_Y_IN      = vec_t'(1) << 45;
  localparam vec_t V_ZLOW_IN   = vec_t'(1) << 44;
  localparam vec_t V_ZHIGH_IN  = vec_t'(1) << 43;
  localparam vec_t V_ZLOW_OUT  = vec_t'(1) << 42;
  localparam vec_t V_ZHIGH_OUT = vec_t'(1) << 41;
  localparam vec_t V_HI_IN     = vec_t'(1) << 40;
  localparam vec_t V_LO_IN     = vec_t'(1) << 39;
  localparam vec_t V_HALTED    = vec_t'(1) << 38;
  localparam vec_t V_ILLEGAL   = vec_t'(1) << 37;
  localparam vec_t V_T0 = V_PC_OUT | V_MAR_IN | V_INC_PC | V_ZLOW_IN | V_ZHIGH_IN;
  localparam vec_t V_T1 = V_ZLOW_OUT | V_PC_IN | V_READ | V_MDR_IN;
  localparam vec_t V_T2 = V_MDR_OUT | V_IR_IN;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
  localparam logic [4:0] SHL = 5'b01011, MUL = 5'b01111, DIV = 5'b10000;
  localparam logic [4:0] NOP = 5'b11010, HLT = 5'b11011, BAD = 5'b11111;

  logic clk = 1'b0;
  logic clr, run, mem_rdy;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
  logic zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in, halted, illegal;
  logic [NREG-1:0] rin, rout;
  logic [OPW-1:0]  alu_op;
`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  alu_instr_control_unit #(.NREG(NREG), .OPW(OPW)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .zlow_in(zlow_in), .zhigh_in(zhigh_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .hi_in(hi_in), .lo_in(lo_in), .rin(rin), .rout(rout), .alu_op(alu_op),
    .halted(halted), .illegal(illegal)
`ifdef CU_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  vec_t obs;
  assign obs = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in, halted, illegal,
                rin, rout, alu_op};

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;
  int   q_cyc[$];
  vec_t q_v[$];
  string q_n[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t v_rin(input int i);  return vec_t'(1) << (21 + i); endfunction
  function automatic vec_t v_rout(input int i); return vec_t'(1) << (5 + i);  endfunction
  function automatic vec_t v_alu(input logic [4:0] o); return vec_t'(o); endfunction
  function automatic logic [31:0] mk_ir(input logic [4:0] o, input int a, input int b, input int c);
    return {o, 4'(a), 4'(b), 4'(c), 15'h0};
  endfunction

  task automatic push(input int c, input vec_t v, input string n);
    q_cyc.push_back(c);
    q_v.push_back(v);
    q_n.push_back(n);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_fetch(input int t0, input int stalls);
    push(t0, V_T0, "t0");
    for (int i = 0; i <= stalls; i++) push(t0 + 1 + i, V_T1, "t1");
    push(t0 + 2 + stalls, V_T2, "t2");
  endtask

  // Called at a negedge; the instruction's T0 is the next cycle.
  task automatic do_instr(input logic [4:0] op, input int ra, input int rb, input int rc,
                          input int stalls, input logic run_next);
    int t0, t3, tl;
    logic alu, md;
    alu = (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                      5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000});
    md  = (op == MUL) || (op == DIV);
    t0 = cyc + 1;
    ir = mk_ir(op, ra, rb, rc);
    run = 1'b1;
    push_fetch(t0, stalls);
    t3 = t0 + 3 + stalls;
    tl = t3;
    if (alu) begin
      push(t3, v_rout(rb) | V_Y_IN, "t3");
      push(t3 + 1, v_rout(rc) | v_alu(op) | V_ZLOW_IN | V_ZHIGH_IN, "t4");
      if (md) begin
        push(t3 + 2, V_ZLOW_OUT | V_LO_IN, "t5_lo");
        push(t3 + 3, V_ZHIGH_OUT | V_HI_IN, "t6_hi");
        tl = t3 + 3;
      end else begin
        push(t3 + 2, V_ZLOW_OUT | v_rin(ra), "t5_wb");
        tl = t3 + 2;
      end
      exp_ret++;
    end else if (op == NOP) begin
      push(t3, '0, "t3_nop");
    end else begin
      push(t3, V_ILLEGAL, "t3_illegal");
    end
    if (!run_next) push(tl + 1, '0, "idle_after");
    if (stalls > 0) begin
      wait_cyc(t0);
      mem_rdy = 1'b0;
      wait_cyc(t0 + 1 + stalls);
      mem_rdy = 1'b1;
    end
    if (alu) begin
      wait_cyc(t3);
      ir = ~ir;
    end
    wait_cyc(tl);
    run = run_next;
    if (!run_next) wait_cyc(tl + 1);
  endtask

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    #2;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_chk++;
      if (q_cyc[0] < cyc) begin
        n_fail++;
        $display("FAIL %s: expected at cycle %0d, not sampled (now %0d)", q_n[0], q_cyc[0], cyc);
      end else if (obs !== q_v[0]) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %h, expected %h", q_n[0], cyc, obs, q_v[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_v.pop_front());
      void'(q_n.pop_front());
    end
  end

  // Bus-driver exclusivity holds in every cycle.
  always @(negedge clk) begin
    #1;
    n_chk++;
    if ((32'(pc_out) + 32'(mdr_out) + 32'(zlow_out) + 32'(zhigh_out) + 32'($countones(rout))) > 1) begin
      n_fail++;
      $display("FAIL bus_exclusive @cyc %0d: drivers pc=%b mdr=%b zl=%b zh=%b rout=%h, required at most one",
               cyc, pc_out, mdr_out, zlow_out, zhigh_out, rout);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    clr = 1'b1; run = 1'b0; mem_rdy = 1'b1; ir = '0;
    @(negedge clk);
    push(cyc, '0, "reset");
    push(cyc + 1, '0, "reset_hold");
    push(cyc + 2, '0, "idle_norun");
    push(cyc + 3, '0, "idle_norun2");
    wait_cyc(cyc + 1);
    clr = 1'b0;
    ir = mk_ir(ADD, 1, 2, 3);
    wait_cyc(cyc + 2);

    do_instr(AND_, 1, 2, 3, 0, 1'b1);
    do_instr(SUB, 7, 8, 9, 0, 1'b0);
    do_instr(OR_, 10, 11, 12, 3, 1'b0);
    do_instr(MUL, 1, 4, 5, 0, 1'b1);
    do_instr(DIV, 15, 14, 0, 0, 1'b1);
    do_instr(BAD, 2, 3, 4, 0, 1'b1);
    do_instr(NOP, 0, 0, 0, 0, 1'b1);
    do_instr(SHL, 0, 15, 13, 1, 1'b0);
    do_instr(BAD, 5, 5, 5, 0, 1'b0);

`ifdef CU_RETIRE_COUNT_EN
    #3;
    n_chk++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL retired_count: got %0d, expected %0d", retired, exp_ret);
    end
    @(negedge clk);
`endif

    t0 = cyc + 1;
    ir = mk_ir(ADD, 6, 1, 2);
    run = 1'b1;
    push_fetch(t0, 0);
    push(t0 + 3, v_rout(1) | V_Y_IN, "t3_pre_clr");
    push(t0 + 4, '0, "clr_async");
    push(t0 + 5, '0, "clr_hold");
    push(t0 + 6, '0, "post_clr_idle");
    wait_cyc(t0 + 4);
    clr = 1'b1;
    run = 1'b0;
    exp_ret = 0;
    wait_cyc(t0 + 5);
    clr = 1'b0;
    wait_cyc(t0 + 6);
    do_instr(ADD, 6, 1, 2, 0, 1'b0);

    t0 = cyc + 1;
    ir = mk_ir(HLT, 0, 0, 0);
    run = 1'b1;
    push_fetch(t0, 0);
    push(t0 + 3, '0, "t3_halt");
    for (int i = 4; i <= 24; i++) push(t0 + i, V_HALTED, "halted");
    wait_cyc(t0 + 24);

`ifdef CU_RETIRE_COUNT_EN
    #3;
    n_chk++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL retired_after_halt: got %0d, expected %0d", retired, exp_ret);
    end
`endif

    for (int i = 0; i < 50 && q_cyc.size() > 0; i++) @(negedge clk);
    #4;
    n_chk++;
    if (q_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_cyc.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
